// File: rtl/sync_updown_mod_counter_pkg.sv
// -----------------------------------------------------------------------------
// sync_updown_mod_counter_pkg
// Shared constants and helpers for the synchronous up/down modulus counter.
//   up / down   : values of the direction input m
//   wrap / sat  : values of the SATURATE parameter
//   clamp_load  : limits a parallel-load value to the legal count range
// -----------------------------------------------------------------------------
package sync_updown_mod_counter_pkg;

    localparam logic UP   = 1'b0;
    localparam logic DOWN = 1'b1;

    localparam int WRAP = 0;
    localparam int SAT  = 1;

    // Out-of-range load values are pinned to the top of the count range.
    function automatic int clamp_load(input int value, input int modulus);
        return (value < modulus) ? value : (modulus - 1);
    endfunction

endpackage

// File: rtl/updown_count_slice.sv
// -----------------------------------------------------------------------------
// updown_count_slice
// One bit of the up/down counter built as a toggle cell.
// Ports:
//   clk    : clock, rising edge
//   clr    : synchronous active-high clear (highest priority)
//   dir    : count direction (UP / DOWN)
//   ld     : synchronous load strobe
//   ld_val : value loaded into this bit when ld is high
//   tog    : toggle enable produced by the lookahead in the top
//   q      : registered bit value
//   prop   : carry (up) / borrow (down) propagate term of this bit
// -----------------------------------------------------------------------------
module updown_count_slice
    import sync_updown_mod_counter_pkg::*;
(
    input  logic clk,
    input  logic clr,
    input  logic dir,
    input  logic ld,
    input  logic ld_val,
    input  logic tog,
    output logic q,
    output logic prop
);

    // Counting up, a bit passes the carry on when it is 1; counting down,
    // it passes the borrow on when it is 0.
    assign prop = (dir == DOWN) ? ~q : q;

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= 1'b0;
        end else if (ld) begin
            q <= ld_val;
        end else if (tog) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/sync_updown_mod_counter.sv
// -----------------------------------------------------------------------------
// sync_updown_mod_counter
// Synchronous up/down counter with programmable modulus, parallel load and
// wrap or saturate behaviour at the terminal value.
// Parameters:
//   WIDTH    : counter width in bits (1..16)
//   MODULUS  : count range 0..MODULUS-1 (2..2**WIDTH)
//   SATURATE : WRAP (0) wraps at the terminal value, SAT (1) holds there
// Ports:
//   clk  : clock, all state changes on the rising edge
//   clr  : synchronous active-high clear, beats load and en
//   m    : direction, 0 = up, 1 = down
//   en   : count enable
//   load : parallel load strobe, beats en
//   d    : parallel load value (clamped to MODULUS-1)
//   q    : registered count
//   tc   : terminal-count flag (combinational), marks the wrap/stall cycle
//   zero : high while q == 0 (combinational)
// -----------------------------------------------------------------------------
module sync_updown_mod_counter
    import sync_updown_mod_counter_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int MODULUS  = 8,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             m,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             zero
);

    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $fatal(1, "sync_updown_mod_counter: WIDTH must be in 1..16");
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $fatal(1, "sync_updown_mod_counter: MODULUS must be in 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULUS - 1);

    logic             at_term;
    logic             do_load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] tog;

    // The slices only know how to toggle in binary. At the terminal value the
    // top either reloads the wrap target through the load path (WRAP) or
    // withholds the count enable (SAT), so a non power-of-two modulus never
    // steps outside 0..MODULUS-1. For MODULUS == 2**WIDTH the reloaded value
    // is exactly what binary overflow/underflow would produce.
    always_comb begin
        logic run;

        at_term = (m == UP) ? (q == TOP_VAL) : (q == '0);
        tc      = en & ~load & ~clr & at_term;
        zero    = (q == '0);

        do_load = load | (en & at_term & (SATURATE == WRAP));

        if (load) begin
            load_val = WIDTH'(clamp_load(int'(d), MODULUS));
        end else if (m == UP) begin
            load_val = '0;
        end else begin
            load_val = TOP_VAL;
        end

        // Bit i toggles when counting is enabled and every lower bit
        // propagates the carry/borrow; all terms come straight from the
        // registered bits, so every slice changes on the same clock edge.
        run = en & ~load & ~at_term;
        for (int i = 0; i < WIDTH; i++) begin
            tog[i] = run;
            run    = run & prop[i];
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        updown_count_slice u_slice (
            .clk    (clk),
            .clr    (clr),
            .dir    (m),
            .ld     (do_load),
            .ld_val (load_val[i]),
            .tog    (tog[i]),
            .q      (q[i]),
            .prop   (prop[i])
        );
    end

endmodule

// File: tb/tb_sync_updown_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_sync_updown_mod_counter
// Drives three counter configurations from one shared stimulus stream:
//   dut_a : WIDTH=4, MODULUS=10, SATURATE=0
//   dut_b : WIDTH=4, MODULUS=10, SATURATE=1
//   dut_c : WIDTH=3, MODULUS=8,  SATURATE=0 (low three bits of d)
// An arithmetic reference model is compared against every DUT each cycle,
// and directed sequences carry hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_sync_updown_mod_counter;

    logic       clk  = 1'b0;
    logic       clr  = 1'b0;
    logic       m    = 1'b0;
    logic       en   = 1'b0;
    logic       load = 1'b0;
    logic [3:0] d    = 4'd0;

    logic [3:0] qa, qb;
    logic [2:0] qc;
    logic       tca, tcb, tcc;
    logic       za, zb, zc;

    int errors = 0;
    int checks = 0;

    int mqa = 0;
    int mqb = 0;
    int mqc = 0;
    bit model_valid = 1'b0;

    always #5 clk = ~clk;

    sync_updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_a (
        .clk(clk), .clr(clr), .m(m), .en(en), .load(load), .d(d),
        .q(qa), .tc(tca), .zero(za)
    );

    sync_updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_b (
        .clk(clk), .clr(clr), .m(m), .en(en), .load(load), .d(d),
        .q(qb), .tc(tcb), .zero(zb)
    );

    sync_updown_mod_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) dut_c (
        .clk(clk), .clr(clr), .m(m), .en(en), .load(load), .d(d[2:0]),
        .q(qc), .tc(tcc), .zero(zc)
    );

    // Next count from the behavioural rules: clear, then load with clamp,
    // then count with wrap or hold at the ends of 0..modulus-1.
    function automatic int model_next(input int cur, input int modulus, input int sat,
                                      input bit c, input bit l, input bit e,
                                      input bit dn, input int dv);
        if (c) return 0;
        if (l) return (dv < modulus) ? dv : modulus - 1;
        if (!e) return cur;
        if (!dn) begin
            if (cur == modulus - 1) return sat ? cur : 0;
            return cur + 1;
        end
        if (cur == 0) return sat ? cur : modulus - 1;
        return cur - 1;
    endfunction

    function automatic int model_tc(input int cur, input int modulus, input bit c,
                                    input bit l, input bit e, input bit dn);
        return (e && !l && !c && ((!dn && cur == modulus - 1) || (dn && cur == 0))) ? 1 : 0;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic setInputs(input bit c, input bit l, input bit e, input bit dn,
                             input logic [3:0] dv);
        clr  = c;
        load = l;
        en   = e;
        m    = dn;
        d    = dv;
    endtask

    task automatic applyStimulus(input bit c, input bit l, input bit e, input bit dn,
                                 input logic [3:0] dv);
        setInputs(c, l, e, dn, dv);
        @(posedge clk);
        #1;
    endtask

    // Reference model advances on every rising edge once a clear has been seen.
    always @(posedge clk) begin
        if (clr) model_valid = 1'b1;
        mqa = model_next(mqa, 10, 0, clr, load, en, m, int'(d));
        mqb = model_next(mqb, 10, 1, clr, load, en, m, int'(d));
        mqc = model_next(mqc, 8, 0, clr, load, en, m, int'(d[2:0]));
    end

    // Mid-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("model.a.q",    int'(qa),  mqa);
            checkOutput("model.a.tc",   int'(tca), model_tc(mqa, 10, clr, load, en, m));
            checkOutput("model.a.zero", int'(za),  (mqa == 0) ? 1 : 0);
            checkOutput("model.b.q",    int'(qb),  mqb);
            checkOutput("model.b.tc",   int'(tcb), model_tc(mqb, 10, clr, load, en, m));
            checkOutput("model.b.zero", int'(zb),  (mqb == 0) ? 1 : 0);
            checkOutput("model.c.q",    int'(qc),  mqc);
            checkOutput("model.c.tc",   int'(tcc), model_tc(mqc, 8, clr, load, en, m));
            checkOutput("model.c.zero", int'(zc),  (mqc == 0) ? 1 : 0);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int up10 [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        int down10 [3] = '{9, 8, 7};
        int sat_up [5] = '{8, 9, 9, 9, 9};

        repeat (2) @(posedge clk);
        #1;

        // Reset state
        applyStimulus(1, 0, 0, 0, 4'd0);
        setInputs(0, 0, 0, 0, 4'd0);
        #1;
        checkOutput("reset.a.q",    int'(qa),  0);
        checkOutput("reset.b.q",    int'(qb),  0);
        checkOutput("reset.c.q",    int'(qc),  0);
        checkOutput("reset.a.zero", int'(za),  1);
        checkOutput("reset.a.tc",   int'(tca), 0);

        // Up count through the modulus-10 wrap
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 0, 1, 0, 4'd0);
            checkOutput("up10.q",    int'(qa),  up10[i]);
            checkOutput("up10.tc",   int'(tca), (up10[i] == 9) ? 1 : 0);
            checkOutput("up10.zero", int'(za),  (up10[i] == 0) ? 1 : 0);
        end

        // Down count from zero wraps to 9
        applyStimulus(1, 0, 0, 0, 4'd0);
        setInputs(0, 0, 1, 1, 4'd0);
        #1;
        checkOutput("down10.tc_at_0",   int'(tca), 1);
        checkOutput("down10.zero_at_0", int'(za),  1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 1, 4'd0);
            checkOutput("down10.q",    int'(qa),  down10[i]);
            checkOutput("down10.zero", int'(za),  0);
            checkOutput("down10.tc",   int'(tca), 0);
        end

        // Saturating up count stalls at 9, then steps back down
        applyStimulus(0, 1, 0, 0, 4'd7);
        checkOutput("sat.load7", int'(qb), 7);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 1, 0, 4'd0);
            checkOutput("sat.q",  int'(qb),  sat_up[i]);
            checkOutput("sat.tc", int'(tcb), (sat_up[i] == 9) ? 1 : 0);
        end
        applyStimulus(0, 0, 1, 1, 4'd0);
        checkOutput("sat.down", int'(qb), 8);

        // Load clamp and load beating en
        applyStimulus(0, 1, 0, 0, 4'd12);
        checkOutput("load.clamp.a", int'(qa), 9);
        checkOutput("load.clamp.b", int'(qb), 9);
        checkOutput("load.clamp.c", int'(qc), 4);
        setInputs(0, 1, 1, 0, 4'd5);
        #1;
        checkOutput("load.tc_masked", int'(tca), 0);
        applyStimulus(0, 1, 1, 0, 4'd5);
        checkOutput("load.wins.a", int'(qa), 5);
        checkOutput("load.wins.b", int'(qb), 5);

        // Clear beats load and en; then hold with m toggling
        applyStimulus(0, 1, 0, 0, 4'd6);
        checkOutput("clr.pre", int'(qa), 6);
        applyStimulus(1, 1, 1, 0, 4'd3);
        checkOutput("clr.wins.a", int'(qa), 0);
        checkOutput("clr.wins.c", int'(qc), 0);
        setInputs(1, 0, 1, 1, 4'd0);
        #1;
        checkOutput("clr.tc_masked", int'(tca), 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, i[0], 4'd0);
            checkOutput("hold.q",  int'(qa),  0);
            checkOutput("hold.tc", int'(tca), 0);
        end

        // 3-bit binary sweep up and down
        applyStimulus(1, 0, 0, 0, 4'd0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 1, 0, 4'd0);
            checkOutput("bin.up", int'(qc), (i + 1) % 8);
        end
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, 0, 1, 1, 4'd0);
            checkOutput("bin.down", int'(qc), (((7 - i) % 8) + 8) % 8);
        end

        setInputs(0, 0, 0, 0, 4'd0);
        repeat (2) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
